input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/debounce_pkg.sv | 32 +++
 rtl/debounce_channel.sv | 158 +++++++++++++++
 rtl/input_debouncer.sv | 43 ++++
 tb/tb_input_debouncer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : debounce_pkg                                                  |
// | Purpose  : Shared types and constants for the input debouncer: the       |
// |            per-channel FSM state encoding, the default debounce length   |
// |            and the counter-width helper.                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package debounce_pkg;

  // Per-channel debounce state. The two IDLE states hold a settled level;
  // the two PEND states are counting towards accepting the opposite level.
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    PEND_HI = 2'd1,
    IDLE_HI = 2'd2,
    PEND_LO = 2'd3
  } deb_state_e;

  // Default number of stable synchronized cycles needed to accept a change.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Largest supported debounce length (keeps the counter at 16 bits max).
  localparam int MAX_DEBOUNCE_CYCLES = 65535;

  // Counter just wide enough to hold the value DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : debounce_channel                                              |
// | Purpose  : One debounced input bit: two-flop synchronizer, four-state    |
// |            debounce FSM with saturating-by-construction counter, and     |
// |            optional registered rise/fall edge pulses.                    |
// | Config   : DEBOUNCER_EDGE_PULSE_EN - when defined, rise_pulse and        |
// |            fall_pulse are live registered pulses; when undefined they    |
// |            are tied to 0 and no pulse flops exist.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module debounce_channel
  import debounce_pkg::*;
#(
  // Legal range 1..MAX_DEBOUNCE_CYCLES.
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int               CNT_W      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

  // Synchronizer stages: meta_q may go metastable, only sync_q is consumed.
  logic meta_q;
  logic sync_q;

  // FSM state, counter and debounced level.
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             clean_q, clean_d;

  // Single-cycle strobes marking the edge on which a new level is accepted.
  logic accept_rise;
  logic accept_fall;

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_in;
      sync_q <= meta_q;
    end
  end

  // Next-state logic: any disagreeing sample in a PEND state drops back to
  // IDLE, so the count always restarts from scratch after a bounce. The
  // counter stops at CNT_TARGET because reaching it leaves the PEND state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (sync_q) begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PEND_HI: begin
        if (!sync_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TARGET) begin
          state_d     = IDLE_HI;
          cnt_d       = '0;
          accept_rise = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync_q) begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PEND_LO: begin
        if (sync_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TARGET) begin
          state_d     = IDLE_LO;
          cnt_d       = '0;
          accept_fall = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounced level only moves on an accept strobe.
  always_comb begin
    clean_d = clean_q;
    if (accept_rise) begin
      clean_d = 1'b1;
    end else if (accept_fall) begin
      clean_d = 1'b0;
    end
  end

  // FSM, counter and output level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_out = clean_q;

`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic rise_q;
  logic fall_q;

  // Pulses register alongside clean_q so they coincide with the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept_rise;
      fall_q <= accept_fall;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : input_debouncer                                               |
// | Purpose  : NUM_CH independent debounced inputs. Each bit gets its own    |
// |            synchronizer, debounce FSM and counter; a change held on      |
// |            raw_in appears on clean_out DEBOUNCE_CYCLES+2 edges after it  |
// |            is first sampled.                                             |
// | Config   : DEBOUNCER_EDGE_PULSE_EN - enables registered rise_pulse /     |
// |            fall_pulse outputs; otherwise both are constant 0.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module input_debouncer
  import debounce_pkg::*;
#(
  // Consecutive stable synchronized cycles to accept a change, 1..65535.
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  // Number of independent channels.
  parameter int NUM_CH          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  // One self-contained debounce channel per input bit; no shared state.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in[ch]),
      .clean_out  (clean_out[ch]),
      .rise_pulse (rise_pulse[ch]),
      .fall_pulse (fall_pulse[ch])
    );
  end

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_input_debouncer                                            |
// | Purpose  : Directed self-checking bench for input_debouncer with         |
// |            DEBOUNCE_CYCLES=4, NUM_CH=2 and a 10 ns clock. Pulse          |
// |            expectations follow DEBOUNCER_EDGE_PULSE_EN.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_input_debouncer;

`ifdef DEBOUNCER_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] raw_in;
  logic [1:0] clean_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;

  int n_cmp;
  int n_err;

  input_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .NUM_CH          (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse value expected from the build: live pulses only with the macro.
  function automatic logic [1:0] pe(input logic [1:0] v);
    return PULSE_EN ? v : 2'b00;
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] c,
                         input logic [1:0] r, input logic [1:0] f);
    chk({tag, ".clean"}, clean_out,  c);
    chk({tag, ".rise"},  rise_pulse, r);
    chk({tag, ".fall"},  fall_pulse, f);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;

    // Reset held 20 ns with both inputs high; outputs must stay 0.
    rst    = 1'b1;
    raw_in = 2'b11;
    #12;
    chk_all("rst_hold", 2'b00, 2'b00, 2'b00);
    #8;
    rst = 1'b0;                       // t=20, first sampling edge at t=25 (E)
    tick();                           // E
    chk_all("rel_e0", 2'b00, 2'b00, 2'b00);
    for (int i = 1; i <= 5; i++) begin
      tick();                         // E+1 .. E+5
      chk_all("rel_wait", 2'b00, 2'b00, 2'b00);
    end
    tick();                           // E+6
    chk_all("rel_rise", 2'b11, pe(2'b11), 2'b00);
    tick();
    chk_all("rel_after", 2'b11, 2'b00, 2'b00);

    // Both channels fall together.
    raw_in = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fall_wait.clean", clean_out, 2'b11);
    end
    tick();
    chk_all("fall_both", 2'b00, 2'b00, pe(2'b11));
    tick();
    chk_all("fall_after", 2'b00, 2'b00, 2'b00);

    // Channel 0 rises alone; channel 1 untouched.
    raw_in = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all("ch0_wait", 2'b00, 2'b00, 2'b00);
    end
    tick();
    chk_all("ch0_rise", 2'b01, pe(2'b01), 2'b00);
    tick();
    chk_all("ch0_after", 2'b01, 2'b00, 2'b00);

    // Channel 1: one-cycle glitch then three-cycle glitch, both rejected.
    raw_in = 2'b11;
    tick();
    raw_in = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("glitch1", 2'b01, 2'b00, 2'b00);
    end
    raw_in = 2'b11;
    tick();
    tick();
    tick();
    raw_in = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("glitch3", 2'b01, 2'b00, 2'b00);
    end

    // Bring channel 0 low again.
    raw_in = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    tick();
    chk_all("ch0_fall", 2'b00, 2'b00, pe(2'b01));

    // Channel 0 bounces 1,0,1 then holds; count restarts at last 0->1.
    tick();
    raw_in = 2'b01;
    tick();
    raw_in = 2'b00;
    tick();
    raw_in = 2'b01;                   // sampled at next edge E'
    for (int i = 0; i < 6; i++) begin
      tick();                         // E' .. E'+5
      chk_all("bounce_wait", 2'b00, 2'b00, 2'b00);
    end
    tick();                           // E'+6
    chk_all("bounce_rise", 2'b01, pe(2'b01), 2'b00);
    tick();
    chk_all("bounce_after", 2'b01, 2'b00, 2'b00);

    // Reset two cycles into PEND_LO on channel 0.
    raw_in = 2'b00;
    tick();                           // E: sampled
    tick();                           // E+1: reaches sync
    tick();                           // E+2: PEND_LO, count 1
    tick();                           // E+3: count 2
    chk_all("pend_lo", 2'b01, 2'b00, 2'b00);
    rst = 1'b1;
    #1;
    chk_all("rst_async", 2'b00, 2'b00, 2'b00);
    tick();
    chk_all("rst_in", 2'b00, 2'b00, 2'b00);
    #4;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("post_rst", 2'b00, 2'b00, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_input_debouncer
`default_nettype wire
